// File: rtl/prog_timer_if.sv
// Control/status bundle between the wrapper layer and prog_timer.
// The wrapper drives the master side; the timer is the slave.
interface prog_timer_if #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
);
    logic               start_i;
    logic               stop_i;
    logic               pause_i;
    logic               mode_i;
    logic [WIDTH-1:0]   period_i;
    logic [PRESC_W-1:0] presc_i;
    logic               irq_clr_i;
    logic [WIDTH-1:0]   count_o;
    logic               busy_o;
    logic               done_o;
    logic               irq_o;

    modport master (
        output start_i, stop_i, pause_i, mode_i, period_i, presc_i, irq_clr_i,
        input  count_o, busy_o, done_o, irq_o
    );

    modport slave (
        input  start_i, stop_i, pause_i, mode_i, period_i, presc_i, irq_clr_i,
        output count_o, busy_o, done_o, irq_o
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable down-counting timer: one-shot or auto-reload, pause/resume,
// abort, one-cycle done pulse and a sticky interrupt flag.
// Optional tick prescaler compiled in with `define PROG_TIMER_PRESCALE_EN;
// without it the counter ticks every clock and presc_i is ignored.
module prog_timer #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic         clk_i,
    input  logic         arst_i,
    prog_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic             mode_q;
    logic             done_q;
    logic             irq_q;

    logic             active;
    logic             start_ok;
    logic             advance;
    logic             tick;
    logic             expire;

    // A start with a zero period is treated as if no start had been issued.
    assign start_ok = bus.start_i && (bus.period_i != '0);
    assign active   = (state == RUN) || (state == PAUSE);
    // Edges on which the count may move: nothing of higher priority claims them.
    assign advance  = active && !bus.stop_i && !start_ok && !bus.pause_i;
    assign expire   = advance && tick && (count == ONE);

`ifdef PROG_TIMER_PRESCALE_EN
    localparam logic [PRESC_W-1:0] PONE = PRESC_W'(1);
    logic [PRESC_W-1:0] presc_cnt;

    assign tick = (presc_cnt == bus.presc_i);

    // Prescaler: counts 0..presc_i while advancing, frozen in PAUSE, cleared on start/stop.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            presc_cnt <= '0;
        end else if (bus.stop_i || start_ok) begin
            presc_cnt <= '0;
        end else if (advance) begin
            presc_cnt <= tick ? '0 : presc_cnt + PONE;
        end
    end
`else
    logic unused_presc;
    assign unused_presc = ^bus.presc_i;
    assign tick         = 1'b1;
`endif

    // Main control: priority stop > start > pause > tick, plus done/irq flags.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state  <= IDLE;
            count  <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every right-hand side sees
            // the pre-edge value, independent of statement order.
            done_q <= expire;
            irq_q  <= expire | (irq_q & ~bus.irq_clr_i);
            if (bus.stop_i) begin
                state <= IDLE;
                count <= '0;
            end else if (start_ok) begin
                count  <= bus.period_i;
                mode_q <= bus.mode_i;
                state  <= bus.pause_i ? PAUSE : RUN;
            end else if (active) begin
                if (bus.pause_i) begin
                    state <= PAUSE;
                end else begin
                    state <= RUN;
                    if (tick) begin
                        if (count == ONE) begin
                            // Reload in the same edge so zero is never visible.
                            if (mode_q && (bus.period_i != '0)) begin
                                count <= bus.period_i;
                            end else begin
                                count <= '0;
                                state <= DONE;
                            end
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end
            end
        end
    end

    assign bus.count_o = count;
    assign bus.busy_o  = active;
    assign bus.done_o  = done_q;
    assign bus.irq_o   = irq_q;
endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios plus randomized
// stimulus, compared every cycle against a behavioural model.
module tb_prog_timer;
    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;
`ifdef PROG_TIMER_PRESCALE_EN
    localparam bit PRESC_EN = 1'b1;
`else
    localparam bit PRESC_EN = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;

    prog_timer_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

    prog_timer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: is a countdown live, ticks remaining, mode, flags.
    bit m_active;
    bit m_mode;
    bit m_done;
    bit m_irq;
    int m_count;
    int m_phase;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_mode = 0; m_done = 0; m_irq = 0; m_count = 0; m_phase = 0;
    endtask

    // One clock edge of the timer described by its rules, using current inputs.
    task automatic model_edge();
        bit expired = 0;
        bit tk;
        int per = int'(bus.period_i);
        m_done = 0;
        if (bus.stop_i) begin
            m_active = 0; m_count = 0; m_phase = 0;
        end else if (bus.start_i && per != 0) begin
            m_active = 1; m_count = per; m_mode = bus.mode_i; m_phase = 0;
        end else if (m_active && !bus.pause_i) begin
            if (PRESC_EN) begin
                tk = (m_phase == int'(bus.presc_i));
                m_phase = tk ? 0 : (m_phase + 1) % (1 << PRESC_W);
            end else begin
                tk = 1;
            end
            if (tk) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    expired = 1;
                    m_done  = 1;
                    if (m_mode && per != 0) m_count = per;
                    else m_active = 0;
                end
            end
        end
        m_irq = expired | (m_irq & !bus.irq_clr_i);
    endtask

    task automatic compare(input string tag);
        check({tag, ".count"}, 32'(bus.count_o), 32'(m_count));
        check({tag, ".busy"},  32'(bus.busy_o),  32'(m_active));
        check({tag, ".done"},  32'(bus.done_o),  32'(m_done));
        check({tag, ".irq"},   32'(bus.irq_o),   32'(m_irq));
    endtask

    task automatic step(input string tag);
        @(posedge clk_i);
        model_edge();
        #1;
        compare(tag);
    endtask

    task automatic idle_inputs();
        bus.start_i = 0; bus.stop_i = 0; bus.pause_i = 0; bus.mode_i = 0;
        bus.irq_clr_i = 0; bus.period_i = '0; bus.presc_i = '0;
    endtask

    task automatic start(input int per, input bit mode);
        bus.period_i = WIDTH'(per);
        bus.mode_i   = mode;
        bus.start_i  = 1;
        step("start");
        bus.start_i  = 0;
    endtask

    int n;
    int pulses;

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare("reset");
        arst_i = 0;

        // Asynchronous reset in the middle of a run with count 5.
        start(8, 0);
        repeat (3) step("pre_rst");
        check("pre_rst_count", 32'(bus.count_o), 5);
        arst_i = 1;
        #1;
        model_reset();
        check("arst_count", 32'(bus.count_o), 0);
        check("arst_busy",  32'(bus.busy_o),  0);
        check("arst_done",  32'(bus.done_o),  0);
        check("arst_irq",   32'(bus.irq_o),   0);
        #1;
        arst_i = 0;

        // One-shot, period 4.
        start(4, 0);
        check("os_load", 32'(bus.count_o), 4);
        for (int i = 1; i <= 4; i++) begin
            step("oneshot");
            check("os_count", 32'(bus.count_o), 32'(4 - i));
            check("os_done",  32'(bus.done_o),  32'(i == 4));
        end
        step("os_after");
        check("os_idle_busy", 32'(bus.busy_o), 0);
        check("os_irq",       32'(bus.irq_o),  1);
        check("os_hold",      32'(bus.count_o), 0);

        // Auto-reload, period 3: five pulses in fifteen cycles.
        start(3, 1);
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            step("reload3");
            check("rl3_done", 32'(bus.done_o), 32'(i % 3 == 0));
            if (bus.done_o) pulses++;
        end
        check("rl3_pulses", 32'(pulses), 5);
        // Restart with period 1: done every cycle.
        start(1, 1);
        for (int i = 0; i < 5; i++) begin
            step("reload1");
            check("rl1_done", 32'(bus.done_o), 1);
        end
        bus.stop_i = 1;
        step("stop");
        bus.stop_i = 0;
        check("stop_busy", 32'(bus.busy_o), 0);

        // Pause three cycles at count 2: done arrives three edges late.
        start(4, 0);
        repeat (2) step("pre_pause");
        check("pause_at", 32'(bus.count_o), 2);
        bus.pause_i = 1;
        for (int i = 0; i < 3; i++) begin
            step("paused");
            check("pause_hold", 32'(bus.count_o), 2);
        end
        bus.pause_i = 0;
        n = 5;
        while (!bus.done_o && n < 20) begin
            step("resume");
            n++;
        end
        check("pause_latency", 32'(n), 7);

        // stop and start together: stop wins, no done.
        start(5, 0);
        step("run");
        bus.stop_i = 1; bus.start_i = 1; bus.period_i = 8'd6;
        step("stop_start");
        bus.stop_i = 0; bus.start_i = 0;
        check("ss_count", 32'(bus.count_o), 0);
        check("ss_busy",  32'(bus.busy_o),  0);
        for (int i = 0; i < 6; i++) step("ss_quiet");

        // irq clear coinciding with expiry: set wins; next clear takes effect.
        bus.irq_clr_i = 1;
        step("clr");
        bus.irq_clr_i = 0;
        check("clr_irq", 32'(bus.irq_o), 0);
        start(2, 0);
        step("irq_run");
        bus.irq_clr_i = 1;
        step("irq_coincide");
        check("irq_setwins", 32'(bus.irq_o), 1);
        step("irq_clear");
        bus.irq_clr_i = 0;
        check("irq_cleared", 32'(bus.irq_o), 0);

        // Start with period 0 is ignored.
        start(0, 0);
        check("p0_busy",  32'(bus.busy_o),  0);
        check("p0_count", 32'(bus.count_o), 0);

        // Prescaler divide-by-3 with period 2.
        bus.presc_i = 4'd2;
        start(2, 0);
        n = 0;
        while (!bus.done_o && n < 20) begin
            step("presc");
            n++;
        end
        check("presc_latency", 32'(n), PRESC_EN ? 6 : 2);
        bus.presc_i = '0;

        // Full-scale period.
        start(255, 0);
        check("fs_load", 32'(bus.count_o), 255);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step("fullscale");
            if (bus.done_o) pulses++;
        end
        check("fs_pulses", 32'(pulses), 1);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.start_i   = ($urandom_range(0, 15) == 0);
            bus.stop_i    = ($urandom_range(0, 63) == 0);
            bus.pause_i   = ($urandom_range(0, 7) == 0);
            bus.irq_clr_i = ($urandom_range(0, 7) == 0);
            bus.mode_i    = 1'($urandom_range(0, 1));
            bus.period_i  = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom_range(0, 255))
                                                         : WIDTH'($urandom_range(0, 6));
            bus.presc_i   = PRESC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                arst_i = 1;
                #1;
                model_reset();
                compare("rand_rst");
                arst_i = 0;
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised successor to the single-shot timer.
- Programmable period, one-shot or auto-reload mode, pause/resume, abort, and a sticky interrupt flag with clear.
- Sits behind a control/wrapper layer.
- Counts down from a runtime-loaded period and signals expiry with a one-cycle done pulse.

Parameters:
- WIDTH, 32, counter and period width in bits (min 2).
- PRESC_W, 8, prescaler divide-value width in bits. Used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  single clock, rising-edge.
- arst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  load period_i and begin counting (single-cycle strobe, level also accepted).
- stop_i  in  1  abort; return to IDLE.
- pause_i  in  1  level; freeze count while high.
- mode_i  in  1  0 = one-shot, 1 = auto-reload; sampled on start.
- period_i  in  WIDTH  terminal period in ticks; sampled on start and on each reload.
- presc_i  in  PRESC_W  tick divider; tick every presc_i+1 clocks.
- irq_clr_i  in  1  clear sticky irq_o.
- count_o  out  WIDTH  current remaining count.
- busy_o  out  1  high in RUN or PAUSE.
- done_o  out  1  one-cycle pulse on each expiry.
- irq_o  out  1  sticky expiry flag.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; count_o = 0; done_o, irq_o, busy_o = 0.
  - Latched mode = 0; prescaler counter = 0.
- State encoding is 2 bits: IDLE, RUN, PAUSE, DONE.
- IDLE / DONE:
  - start_i with period_i != 0: count_o <= period_i, latch mode_i, go RUN.
  - start_i with period_i == 0: ignored; state and outputs unchanged.
- RUN:
  - On each tick: count_o <= count_o - 1.
  - On the tick where count_o == 1: count_o reaches 0, done_o = 1 next cycle, irq_o set.
  - Then one-shot goes to DONE (count_o holds 0).
  - Auto-reload instead sets count_o <= period_i in the same edge (0 never visible) and stays RUN. If period_i is now 0, go DONE instead.
- Latency, tick every clock: start registered at edge k → done_o high during the cycle after edge k+P (P = period).
- PAUSE:
  - Entered from RUN while pause_i = 1; RUN resumes when pause_i = 0.
  - count_o and prescaler counter are frozen; no ticks are lost or gained.
- busy_o = 1 in RUN and PAUSE. It is combinational from the state register.
- Priority per edge: stop_i > start_i > pause_i > tick.
  - stop_i in any state: go IDLE, count_o <= 0, no done_o. irq_o is untouched.
  - start_i in RUN or PAUSE: restart with fresh period_i/mode_i, prescaler cleared. No done_o for the aborted run.
  - start_i and pause_i together from IDLE: load the period, enter PAUSE directly.
- irq_o:
  - Set on expiry; cleared by irq_clr_i.
  - If set and clear coincide, set wins.
- done_o is a registered pulse, exactly one cycle per expiry, including back-to-back reloads with period 1 (done_o high every cycle).
- Arithmetic: unsigned, WIDTH bits. Full-scale period 2^WIDTH-1 is legal; the decrement never underflows.

Optional Feature:
- Macro: PROG_TIMER_PRESCALE_EN.
- Defined:
  - A PRESC_W-bit prescaler counts 0..presc_i; tick fires when it equals presc_i, then it wraps to 0.
  - Counter is cleared on start, stop, and reset.
  - presc_i is sampled each cycle; a change mid-count takes effect at the next compare.
  - presc_i = 0 gives a tick every clock.
- Not defined: tick = 1 every clock; presc_i is ignored and the prescaler logic is absent.

Test Plan:
- Reset: arst_i = 1 mid-run with count_o = 5 → all outputs 0 immediately, without waiting for a clock edge.
- One-shot: period_i = 4, mode 0, start → count_o 4,3,2,1,0; done_o one cycle, 4 cycles after start edge; irq_o = 1; state DONE; busy_o = 0.
- Auto-reload: period_i = 3, mode 1 → done_o every 3 cycles, 5 consecutive pulses. period_i = 1 → done_o constant high.
- Pause/stop:
  - Pause 3 cycles at count_o = 2 → count holds 2, done_o delayed exactly 3 cycles.
  - stop_i with start_i same cycle → IDLE, count_o = 0, no done_o.
- irq / edge cases:
  - irq_clr_i on the same cycle as expiry → irq_o stays 1.
  - Next cycle irq_clr_i → irq_o = 0.
  - start with period_i = 0 → ignored.
- Prescaler (with macro): presc_i = 2, period_i = 2 → done_o 6 clocks after start. Without macro, same stimulus → 2 clocks.
